output_channel_credit_tracker: RTL and testbench

Tracks, per output channel, the slots reserved by in-flight instructions and the slots occupied in the output channel buffer. It produces an exact per-channel full status for the trigger/issue stage, and it replaces pessimistic full marking based on downstream OCI bits. It sits between the issue stage, the writeback stage and the output channel buffers of a PE. It works for any pipeline depth, because reservations are counted rather than inferred from fixed stage taps.

---
 rtl/output_channel_credit_tracker.sv | 143 ++++++++++++++
 tb/tb_output_channel_credit_tracker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/output_channel_credit_tracker.sv
// output_channel_credit_tracker
//
// Tracks two counts for each output channel of a PE. The first is the slots
// reserved by in-flight instructions. The second is the slots occupied in the
// channel buffer. From these it gives the issue stage an exact full status.
// Reservations are counted, not inferred from pipeline stage taps, so the
// block works for any pipeline depth between issue and writeback.
//
// Optional feature macro: TIA_OUTPUT_CHANNEL_DEQUEUE_BYPASS_EN
//   When defined, a same-cycle dequeue frees a slot for a same-cycle issue.
//   channel_full[c] is then also qualified by dequeue[c].

`ifndef TIA_NUM_OUTPUT_CHANNELS
`define TIA_NUM_OUTPUT_CHANNELS 4
`endif

module output_channel_credit_tracker #(
    parameter int  NUM_CHANNELS = `TIA_NUM_OUTPUT_CHANNELS,
    parameter int  BUFFER_DEPTH = 4,
    localparam int COUNT_WIDTH  = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                issue_valid,
    input  logic [NUM_CHANNELS-1:0]             issue_oci,
    input  logic                                squash_valid,
    input  logic [NUM_CHANNELS-1:0]             squash_oci,
    input  logic [NUM_CHANNELS-1:0]             enqueue,
    input  logic [NUM_CHANNELS-1:0]             dequeue,
    output logic [NUM_CHANNELS-1:0]             channel_full,
    output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] reserved_count,
    output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] occupied_count,
    output logic                                protocol_error
);

    // Intermediate sums carry one extra bit. A bypassed issue can make
    // reserved+occupied reach BUFFER_DEPTH+1 for a moment before the
    // same-cycle dequeue brings it back.
    localparam int                 WIDE_WIDTH = COUNT_WIDTH + 1;
    localparam logic [COUNT_WIDTH:0] DEPTH_SUM = WIDE_WIDTH'(BUFFER_DEPTH);

    logic [NUM_CHANNELS-1:0] raw_full;      // reserved+occupied == depth
    logic [NUM_CHANNELS-1:0] occupied_any;  // occupied != 0
    logic [NUM_CHANNELS-1:0] issue_block;   // issue to this channel is illegal
    logic [NUM_CHANNELS-1:0] error_event;   // an illegal event was dropped this cycle
    logic                    protocol_error_q;

`ifdef TIA_OUTPUT_CHANNEL_DEQUEUE_BYPASS_EN
    // A same-cycle dequeue opens a slot for a same-cycle issue. If the channel
    // holds no occupied slot, that dequeue will itself be dropped. The issue
    // is refused in that case so the slot total can never exceed the depth.
    assign channel_full = raw_full & ~dequeue;
    assign issue_block  = channel_full | (raw_full & ~occupied_any);
`else
    assign channel_full = raw_full;
    assign issue_block  = raw_full;
`endif

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_channel
        logic [COUNT_WIDTH-1:0] reserved_q;
        logic [COUNT_WIDTH-1:0] occupied_q;
        logic [COUNT_WIDTH-1:0] reserved_d;
        logic [COUNT_WIDTH-1:0] occupied_d;
        logic [WIDE_WIDTH-1:0]  res_after_issue;
        logic [WIDE_WIDTH-1:0]  res_after_squash;
        logic [WIDE_WIDTH-1:0]  res_after_enqueue;
        logic [WIDE_WIDTH-1:0]  occ_after_enqueue;
        logic [WIDE_WIDTH-1:0]  occ_after_dequeue;
        logic                   issue_req;
        logic                   issue_ok;
        logic                   squash_req;
        logic                   squash_ok;
        logic                   enqueue_ok;
        logic                   dequeue_ok;
        logic                   channel_error;

        assign raw_full[c] = ({1'b0, reserved_q} + {1'b0, occupied_q}) == DEPTH_SUM;
        assign occupied_any[c] = (occupied_q != '0);
        assign reserved_count[c*COUNT_WIDTH +: COUNT_WIDTH] = reserved_q;
        assign occupied_count[c*COUNT_WIDTH +: COUNT_WIDTH] = occupied_q;
        assign error_event[c] = channel_error;

        // Apply this cycle's events in order: issue, squash, enqueue,
        // dequeue. An event that would break a counter is dropped and flagged.
        // NOTE: every signal assigned here gets a value on every path. The
        // value comes either from a default or from a straight-line
        // assignment. That keeps the block purely combinational, with no
        // inferred latch.
        always_comb begin
            issue_req  = issue_valid & issue_oci[c];
            issue_ok   = issue_req & ~issue_block[c];
            res_after_issue = {1'b0, reserved_q} + WIDE_WIDTH'(issue_ok);

            squash_req = squash_valid & squash_oci[c];
            squash_ok  = squash_req & (res_after_issue != '0);
            res_after_squash = res_after_issue - WIDE_WIDTH'(squash_ok);

            enqueue_ok = enqueue[c] & (res_after_squash != '0);
            res_after_enqueue = res_after_squash - WIDE_WIDTH'(enqueue_ok);
            occ_after_enqueue = {1'b0, occupied_q} + WIDE_WIDTH'(enqueue_ok);

            dequeue_ok = dequeue[c] & (occ_after_enqueue != '0);
            occ_after_dequeue = occ_after_enqueue - WIDE_WIDTH'(dequeue_ok);

            reserved_d = res_after_enqueue[COUNT_WIDTH-1:0];
            occupied_d = occ_after_dequeue[COUNT_WIDTH-1:0];

            channel_error = (issue_req  & ~issue_ok)
                          | (squash_req & ~squash_ok)
                          | (enqueue[c] & ~enqueue_ok)
                          | (dequeue[c] & ~dequeue_ok);
        end

        // Per-channel reservation and occupancy registers.
        // NOTE: the reset clears every count asynchronously. All in-flight
        // reservations are discarded, and no clock is needed to get out of a
        // stale state.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                reserved_q <= '0;
                occupied_q <= '0;
            end else begin
                // NOTE: state registers use non-blocking assignment. Every
                // register then samples the pre-edge values, whatever order
                // the blocks evaluate in.
                reserved_q <= reserved_d;
                occupied_q <= occupied_d;
            end
        end
    end

    // Sticky error flag: set by any dropped event, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            protocol_error_q <= 1'b0;
        end else if (|error_event) begin
            protocol_error_q <= 1'b1;
        end
    end

    assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_output_channel_credit_tracker.sv
// Self-checking bench for output_channel_credit_tracker.
// Uses 4 channels with a buffer depth of 4. Expected states are queued
// before each stimulus step, then popped and compared after the clock edge.

module tb_output_channel_credit_tracker;

    localparam int NCH = 4;
    localparam int DEPTH = 4;
    localparam int CW = 3;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             issue_valid = 1'b0;
    logic [NCH-1:0]   issue_oci = '0;
    logic             squash_valid = 1'b0;
    logic [NCH-1:0]   squash_oci = '0;
    logic [NCH-1:0]   enqueue = '0;
    logic [NCH-1:0]   dequeue = '0;
    logic [NCH-1:0]   channel_full;
    logic [NCH*CW-1:0] reserved_count;
    logic [NCH*CW-1:0] occupied_count;
    logic             protocol_error;

    typedef struct {
        string            tag;
        logic [NCH-1:0]    full;
        logic [NCH*CW-1:0] res;
        logic [NCH*CW-1:0] occ;
        logic              err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    output_channel_credit_tracker #(
        .NUM_CHANNELS(NCH),
        .BUFFER_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .issue_valid(issue_valid),
        .issue_oci(issue_oci),
        .squash_valid(squash_valid),
        .squash_oci(squash_oci),
        .enqueue(enqueue),
        .dequeue(dequeue),
        .channel_full(channel_full),
        .reserved_count(reserved_count),
        .occupied_count(occupied_count),
        .protocol_error(protocol_error)
    );

    always #5 clock = ~clock;

    function automatic logic [NCH*CW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {CW'(a3), CW'(a2), CW'(a1), CW'(a0)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [NCH-1:0] full,
                                input logic [NCH*CW-1:0] res, input logic [NCH*CW-1:0] occ,
                                input logic err);
        sb.push_back('{tag: tag, full: full, res: res, occ: occ, err: err});
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".full"}, 64'(channel_full), 64'(e.full));
        check({e.tag, ".reserved"}, 64'(reserved_count), 64'(e.res));
        check({e.tag, ".occupied"}, 64'(occupied_count), 64'(e.occ));
        check({e.tag, ".error"}, 64'(protocol_error), 64'(e.err));
    endtask

    // Drive one cycle of events, then compare the registered result after the edge.
    task automatic cycle(input logic iv, input logic [NCH-1:0] ioci,
                         input logic sv, input logic [NCH-1:0] soci,
                         input logic [NCH-1:0] enq, input logic [NCH-1:0] deq);
        @(negedge clock);
        issue_valid = iv;
        issue_oci = ioci;
        squash_valid = sv;
        squash_oci = soci;
        enqueue = enq;
        dequeue = deq;
        @(posedge clock);
        #1;
        issue_valid = 1'b0;
        issue_oci = '0;
        squash_valid = 1'b0;
        squash_oci = '0;
        enqueue = '0;
        dequeue = '0;
        compare_next();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        expect_state(tag, '0, '0, '0, 1'b0);
        compare_next();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset state.
        #12;
        expect_state("reset", '0, '0, '0, 1'b0);
        compare_next();
        @(negedge clock);
        reset_n = 1'b1;

        // Four issues fill channel 0; full rises only after the fourth.
        for (int i = 1; i <= 4; i++) begin
            expect_state($sformatf("fill0_%0d", i), (i == 4) ? 4'b0001 : 4'b0000,
                         pk(i, 0, 0, 0), '0, 1'b0);
            cycle(1'b1, 4'b0001, 1'b0, '0, '0, '0);
        end

        // Two enqueues move reservations to occupancy; the dequeue frees a slot.
        expect_state("enq0_a", 4'b0001, pk(3, 0, 0, 0), pk(1, 0, 0, 0), 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 4'b0001, '0);
        expect_state("enq0_b", 4'b0001, pk(2, 0, 0, 0), pk(2, 0, 0, 0), 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 4'b0001, '0);
        expect_state("deq0", 4'b0000, pk(2, 0, 0, 0), pk(1, 0, 0, 0), 1'b0);
        cycle(1'b0, '0, 1'b0, '0, '0, 4'b0001);

        do_reset("reset_sync");

        // Same-cycle issue and squash cancel on channel 0.
        expect_state("issue_squash", '0, pk(0, 1, 0, 0), '0, 1'b0);
        cycle(1'b1, 4'b0011, 1'b1, 4'b0001, '0, '0);

        // Fill channel 2 with reservations, then enqueue all of them.
        for (int i = 1; i <= 4; i++) begin
            expect_state($sformatf("fill2_%0d", i), (i == 4) ? 4'b0100 : 4'b0000,
                         pk(0, 1, i, 0), '0, 1'b0);
            cycle(1'b1, 4'b0100, 1'b0, '0, '0, '0);
        end
        for (int i = 1; i <= 4; i++) begin
            expect_state($sformatf("enq2_%0d", i), 4'b0100, pk(0, 1, 4 - i, 0),
                         pk(0, 0, i, 0), 1'b0);
            cycle(1'b0, '0, 1'b0, '0, 4'b0100, '0);
        end

        // Issue to full channel 2 together with a dequeue.
`ifdef TIA_OUTPUT_CHANNEL_DEQUEUE_BYPASS_EN
        expect_state("full_issue_deq", 4'b0100, pk(0, 1, 1, 0), pk(0, 0, 3, 0), 1'b0);
`else
        expect_state("full_issue_deq", 4'b0000, pk(0, 1, 0, 0), pk(0, 0, 3, 0), 1'b1);
`endif
        cycle(1'b1, 4'b0100, 1'b0, '0, '0, 4'b0100);

        do_reset("reset_clears_error");

        // Underflow events on empty channel 3: flagged, counters hold, flag sticks.
        expect_state("deq3_empty", '0, '0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, '0, 4'b1000);
        expect_state("enq3_empty", '0, '0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 4'b1000, '0);
        expect_state("squash3_empty", '0, '0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1, 4'b1000, '0, '0);
        expect_state("error_sticky", '0, '0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, '0, '0);

        // Build mixed counts, then assert reset mid-cycle.
        expect_state("mix_a", '0, pk(1, 1, 0, 0), '0, 1'b1);
        cycle(1'b1, 4'b0011, 1'b0, '0, '0, '0);
        expect_state("mix_b", '0, pk(0, 1, 0, 0), pk(1, 0, 0, 0), 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 4'b0001, '0);
        expect_state("mix_c", '0, pk(1, 1, 0, 0), pk(1, 0, 0, 0), 1'b1);
        cycle(1'b1, 4'b0001, 1'b0, '0, '0, '0);

        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        expect_state("async_reset", '0, '0, '0, 1'b0);
        compare_next();
        @(negedge clock);
        reset_n = 1'b1;

        expect_state("after_reset_idle", '0, '0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
